// File: rtl/mod_n_stream_fsm_pkg.sv
// Shared types and arithmetic helpers for the mod-N serial divisibility checker.
//   state_t  : frame FSM states
//   mod_add  : (a + b) mod m for a, b < m, via a single conditional subtract
package mod_fsm_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  // Operands are always reduced (< m <= 255), so the sum is < 2m and one
  // subtract is enough; 8-bit operands cover the full legal MOD range.
  function automatic logic [7:0] mod_add(input logic [7:0] a, input logic [7:0] b,
                                         input logic [7:0] m);
    logic [8:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (s >= {1'b0, m}) s = s - {1'b0, m};
    return s[7:0];
  endfunction

endpackage

// File: rtl/mod_n_stream_fsm_if.sv
// Stream/status bundle of the mod-N checker.
//   master : serial source side (drives start, lsb_first, sel; sees status)
//   slave  : the checker (samples stream inputs; drives slow_clock, cout,
//            rem, busy, done)
// rem width follows MOD so it matches the checker's remainder register.
interface mod_n_stream_fsm_if #(parameter int MOD = 3);
  localparam int RW = $clog2(MOD);

  logic          start;
  logic          lsb_first;
  logic          sel;
  logic          slow_clock;
  logic          cout;
  logic [RW-1:0] rem;
  logic          busy;
  logic          done;

  modport master (output start, lsb_first, sel,
                  input  slow_clock, cout, rem, busy, done);
  modport slave  (input  start, lsb_first, sel,
                  output slow_clock, cout, rem, busy, done);
endinterface

// File: rtl/mod_n_stream_fsm_tick_div.sv
// Free-running clock divider producing the per-bit sample tick.
//   clk, reset : system clock, async active-high reset
//   sync_clr   : realigns the phase (divcnt back to 0) on the next edge
//   tick       : high in the last clk cycle of each DIV-cycle period
//   slow_clock : registered, high for the upper half (divcnt >= DIV/2)
module tick_div #(
  parameter int DIV = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic sync_clr,
  output logic tick,
  output logic slow_clock
);
  localparam int            CW   = $clog2(DIV);
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);
  localparam logic [CW-1:0] HALF = CW'(DIV / 2);

  logic [CW-1:0] divcnt, divcnt_nx;

  assign tick = (divcnt == LAST);

  always_comb begin
    divcnt_nx = divcnt + CW'(1);
    if (sync_clr || tick) divcnt_nx = '0;
  end

  // slow_clock is registered from the next count so it stays phase-aligned
  // with divcnt: the tick cycle is always the last high cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      divcnt     <= '0;
      slow_clock <= 1'b0;
    end else begin
      divcnt     <= divcnt_nx;
      slow_clock <= (divcnt_nx >= HALF);
    end
  end
endmodule

// File: rtl/mod_n_stream_fsm.sv
// Serial divisibility checker: tracks the running remainder mod MOD of a
// LEN-bit framed stream, one bit per DIV-cycle tick, MSB- or LSB-first.
//   clk, reset : system clock, async active-high reset
//   bus.start      : begin/restart a frame (wins over a coincident tick)
//   bus.lsb_first  : bit order, captured on start
//   bus.sel        : serial bit, consumed on RUN ticks only
//   bus.slow_clock : divided clock
//   bus.cout       : rem == 0
//   bus.rem        : running remainder, held after the frame ends
//   bus.busy       : frame in progress
//   bus.done       : one-cycle pulse after the last bit
module mod_n_stream_fsm
  import mod_fsm_pkg::*;
#(
  parameter int MOD = 3,
  parameter int DIV = 4,
  parameter int LEN = 8
) (
  input  logic                clk,
  input  logic                reset,
  mod_n_stream_fsm_if.slave   bus
);
  localparam int         RW = $clog2(MOD);
  localparam logic [7:0] M8 = 8'(MOD);

  state_t        state;
  logic [RW-1:0] rem, weight;
  logic [7:0]    bitcnt;
  logic          mode;
  logic          tick;
  logic [7:0]    rem8, wt8, msb_nx, lsb_nx, wt_nx;

  tick_div #(.DIV(DIV)) u_div (
    .clk       (clk),
    .reset     (reset),
    .sync_clr  (bus.start),
    .tick      (tick),
    .slow_clock(bus.slow_clock)
  );

  // MSB-first: rem*2 + bit. LSB-first: rem + bit*2^k, with 2^k mod MOD kept
  // in weight so nothing wider than MOD is ever formed.
  always_comb begin
    rem8   = 8'(rem);
    wt8    = 8'(weight);
    msb_nx = mod_add(mod_add(rem8, rem8, M8), {7'd0, bus.sel}, M8);
    lsb_nx = mod_add(rem8, bus.sel ? wt8 : 8'd0, M8);
    wt_nx  = mod_add(wt8, wt8, M8);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      rem    <= '0;
      weight <= RW'(1);
      bitcnt <= '0;
      mode   <= 1'b0;
    end else if (bus.start) begin
      state  <= RUN;
      rem    <= '0;
      weight <= RW'(1);
      bitcnt <= '0;
      mode   <= bus.lsb_first;
    end else begin
      case (state)
        RUN: if (tick) begin
          rem <= mode ? RW'(lsb_nx) : RW'(msb_nx);
          if (mode) weight <= RW'(wt_nx);
          bitcnt <= bitcnt + 8'd1;
          if (bitcnt == 8'(LEN - 1)) state <= DONE;
        end
        DONE:    state <= IDLE;
        default: ;
      endcase
    end
  end

  assign bus.rem  = rem;
  assign bus.cout = (rem == '0);
  assign bus.busy = (state == RUN);
  assign bus.done = (state == DONE);
endmodule

// File: tb/tb_mod_n_stream_fsm.sv
module tb_mod_n_stream_fsm;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  mod_n_stream_fsm_if #(.MOD(3)) b3 ();
  mod_n_stream_fsm_if #(.MOD(5)) b5 ();
  mod_n_stream_fsm_if #(.MOD(3)) b8 ();

  mod_n_stream_fsm #(.MOD(3), .DIV(4), .LEN(3)) u3 (.clk(clk), .reset(reset), .bus(b3));
  mod_n_stream_fsm #(.MOD(5), .DIV(4), .LEN(4)) u5 (.clk(clk), .reset(reset), .bus(b5));
  mod_n_stream_fsm #(.MOD(3), .DIV(4), .LEN(8)) u8 (.clk(clk), .reset(reset), .bus(b8));

  int n_cmp = 0;
  int n_bad = 0;

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input int obs, input int exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  logic [7:0] slow_exp = 8'b1100_1100;       // bit i = slow_clock i cycles after reset release
  logic       f8_bits [8] = '{1, 0, 1, 1, 0, 0, 1, 0};  // 178, MSB-first
  int         f8_rem  [8] = '{1, 2, 2, 2, 1, 2, 2, 1};
  int         dc, bc;

  initial begin
    reset = 1'b1;
    b3.start = 0; b3.lsb_first = 0; b3.sel = 0;
    b5.start = 0; b5.lsb_first = 0; b5.sel = 0;
    b8.start = 0; b8.lsb_first = 0; b8.sel = 0;
    step(2);
    chk("rst_rem",  int'(b3.rem), 0);
    chk("rst_cout", int'(b3.cout), 1);
    chk("rst_busy", int'(b3.busy), 0);
    chk("rst_done", int'(b3.done), 0);
    chk("rst_slow", int'(b3.slow_clock), 0);
    chk("rst_cout5", int'(b5.cout), 1);
    reset = 1'b0;

    // free-running divider: 0,0,1,1 per period
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("slow_%0d", i), int'(b3.slow_clock), int'(slow_exp[i]));
      step(1);
    end

    // MOD3 LEN3 MSB-first 1,1,0
    b3.lsb_first = 0; b3.start = 1; step(1); b3.start = 0;
    chk("t1_busy0", int'(b3.busy), 1);
    chk("t1_rem0",  int'(b3.rem), 0);
    b3.sel = 1; step(4);
    chk("t1_rem1",  int'(b3.rem), 1);
    chk("t1_cout1", int'(b3.cout), 0);
    b3.sel = 1; step(4);
    chk("t1_rem2",  int'(b3.rem), 0);
    b3.sel = 0; step(3);
    chk("t1_done_early", int'(b3.done), 0);
    chk("t1_busy_early", int'(b3.busy), 1);
    step(1);
    chk("t1_rem3",  int'(b3.rem), 0);
    chk("t1_cout3", int'(b3.cout), 1);
    chk("t1_done",  int'(b3.done), 1);
    chk("t1_busy",  int'(b3.busy), 0);

    // start during DONE, LSB-first 1,1,0
    b3.lsb_first = 1; b3.start = 1; step(1); b3.start = 0;
    chk("t2_done0", int'(b3.done), 0);
    chk("t2_busy0", int'(b3.busy), 1);
    b3.sel = 1; step(4);
    chk("t2_rem1", int'(b3.rem), 1);
    b3.sel = 1; step(4);
    chk("t2_rem2", int'(b3.rem), 0);
    b3.sel = 0; step(4);
    chk("t2_rem3",  int'(b3.rem), 0);
    chk("t2_cout3", int'(b3.cout), 1);
    chk("t2_done",  int'(b3.done), 1);

    // MOD5 LEN4 MSB-first 1,1,1,1
    b5.lsb_first = 0; b5.start = 1; step(1); b5.start = 0;
    b5.sel = 1; step(4);
    chk("t3_rem1", int'(b5.rem), 1);
    step(4);
    chk("t3_rem2", int'(b5.rem), 3);
    step(4);
    chk("t3_rem3",  int'(b5.rem), 2);
    chk("t3_cout3", int'(b5.cout), 0);
    step(4);
    chk("t3_rem4",  int'(b5.rem), 0);
    chk("t3_cout4", int'(b5.cout), 1);
    chk("t3_done",  int'(b5.done), 1);
    step(1);

    // MOD5 LEN4 LSB-first 1,0,1,1 (value 13), then hold in IDLE
    b5.lsb_first = 1; b5.start = 1; step(1); b5.start = 0;
    b5.sel = 1; step(4);
    chk("t4_rem1", int'(b5.rem), 1);
    b5.sel = 0; step(4);
    chk("t4_rem2", int'(b5.rem), 1);
    b5.sel = 1; step(4);
    chk("t4_rem3", int'(b5.rem), 0);
    b5.sel = 1; step(4);
    chk("t4_rem4", int'(b5.rem), 3);
    chk("t4_done", int'(b5.done), 1);
    b5.sel = 1; step(9);
    chk("t4_hold_rem",  int'(b5.rem), 3);
    chk("t4_hold_cout", int'(b5.cout), 0);
    chk("t4_hold_busy", int'(b5.busy), 0);
    chk("t4_hold_done", int'(b5.done), 0);

    // MOD3 LEN8: asynchronous reset after 2 bits
    b8.lsb_first = 0; b8.start = 1; step(1); b8.start = 0;
    b8.sel = 1; step(4);
    chk("t5_rem1", int'(b8.rem), 1);
    b8.sel = 0; step(4);
    chk("t5_rem2", int'(b8.rem), 2);
    #1 reset = 1'b1;
    #1;
    chk("t5_arst_rem",  int'(b8.rem), 0);
    chk("t5_arst_cout", int'(b8.cout), 1);
    chk("t5_arst_busy", int'(b8.busy), 0);
    chk("t5_arst_done", int'(b8.done), 0);
    step(1);
    reset = 1'b0;
    dc = 0; bc = 0;
    for (int i = 0; i < 40; i++) begin
      step(1);
      if (b8.done) dc++;
      if (b8.busy) bc++;
    end
    chk("t5_no_done", dc, 0);
    chk("t5_no_busy", bc, 0);

    // MOD3 LEN8: restart after 5 bits, then full frame 178
    b8.lsb_first = 0; b8.start = 1; step(1); b8.start = 0;
    b8.sel = 1; step(20);
    chk("t6_rem5", int'(b8.rem), 1);
    b8.start = 1; step(1); b8.start = 0;
    chk("t6_rst_rem",  int'(b8.rem), 0);
    chk("t6_rst_busy", int'(b8.busy), 1);
    dc = 0;
    for (int k = 0; k < 7; k++) begin
      b8.sel = f8_bits[k];
      for (int c = 0; c < 4; c++) begin
        step(1);
        if (b8.done) dc++;
      end
      chk($sformatf("t6_rem_b%0d", k), int'(b8.rem), f8_rem[k]);
    end
    b8.sel = f8_bits[7];
    for (int c = 0; c < 3; c++) begin
      step(1);
      if (b8.done) dc++;
    end
    chk("t6_no_early_done", dc, 0);
    step(1);
    chk("t6_rem_b7", int'(b8.rem), f8_rem[7]);
    chk("t6_done",   int'(b8.done), 1);
    chk("t6_busy",   int'(b8.busy), 0);
    step(1);
    chk("t6_done_end", int'(b8.done), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
